// File: rtl/banked_data_mem.sv
// rtl/banked_data_mem.sv - word-addressed data memory with byte-enabled writes and programmable latency
module banked_data_mem #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 8,
    parameter int    LATENCY        = 2,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Req,
    input  logic                    WriteEn,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [DATA_WIDTH/8-1:0] ByteEn,
    output logic                    Ready,
    output logic                    Done,
    output logic [DATA_WIDTH-1:0]   ReadData
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         be_q, be_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        mem_be    = be_q;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                mem_be    = '1;
                // The pointer parks on the last address rather than wrapping.
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (Req) begin
                    we_d    = WriteEn;
                    addr_d  = Address;
                    wdata_d = WriteData;
                    be_d    = ByteEn;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[addr_q];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage has no reset; only the INIT sweep clears it.
    always_ff @(posedge Clk) begin
        for (int b = 0; b < NB; b++) begin
            if (Rst_n && mem_we && mem_be[b]) begin
                mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    assign Ready    = (state_q == S_IDLE);
    assign Done     = done_q;
    assign ReadData = rdata_q;

endmodule

// File: tb/tb_banked_data_mem.sv
// tb/tb_banked_data_mem.sv - self-checking bench for banked_data_mem
module tb_banked_data_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic        we_in;
    logic [3:0]  addr_in;
    logic [31:0] wdata_in;
    logic [3:0]  be_in;
    logic [2:0]  ready_w, done_w;
    logic [31:0] rdata_w [3];

    int n_err = 0;
    int n_checks = 0;
    int lat_of [3] = '{2, 1, 8};
    logic [31:0] model [3][16];

    always #5 clk = ~clk;

    banked_data_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LATENCY(2), .CLEAR_ON_RESET(1), .INIT_FILE("")) u0 (
        .Clk(clk), .Rst_n(rst_n), .Req(req[0]), .WriteEn(we_in), .Address(addr_in),
        .WriteData(wdata_in), .ByteEn(be_in), .Ready(ready_w[0]), .Done(done_w[0]), .ReadData(rdata_w[0]));
    banked_data_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LATENCY(1), .CLEAR_ON_RESET(0), .INIT_FILE("")) u1 (
        .Clk(clk), .Rst_n(rst_n), .Req(req[1]), .WriteEn(we_in), .Address(addr_in),
        .WriteData(wdata_in), .ByteEn(be_in), .Ready(ready_w[1]), .Done(done_w[1]), .ReadData(rdata_w[1]));
    banked_data_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LATENCY(8), .CLEAR_ON_RESET(0), .INIT_FILE("")) u2 (
        .Clk(clk), .Rst_n(rst_n), .Req(req[2]), .WriteEn(we_in), .Address(addr_in),
        .WriteData(wdata_in), .ByteEn(be_in), .Ready(ready_w[2]), .Done(done_w[2]), .ReadData(rdata_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    // Issue one request, hold until accepted, then scramble inputs while busy.
    task automatic access(input int s, input logic we, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output int lat);
        int guard;
        @(negedge clk);
        we_in = we; addr_in = a; wdata_in = d; be_in = be; req[s] = 1'b1;
        guard = 0;
        while (!ready_w[s] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_checks++; n_err++;
            $error("FAIL ready_timeout: observed=%0d expected<100", guard);
        end
        @(posedge clk); #1;
        req[s] = 1'b0; addr_in = ~a; wdata_in = ~d; be_in = ~be; we_in = ~we;
        lat = 0;
        while (!done_w[s] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_w[s];
    endtask

    task automatic op(input int s, input logic we, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be, input string tag);
        logic [31:0] rd;
        int lat;
        access(s, we, a, d, be, rd, lat);
        chk({tag, "_latency"}, lat, lat_of[s]);
        if (we) model[s][a] = merge(model[s][a], d, be);
        else    chk({tag, "_rdata"}, rd, model[s][a]);
    endtask

    initial begin
        int n;
        int g;
        int acc[$];
        logic [31:0] rdq[$];
        logic [31:0] last_rd;
        logic [31:0] held;
        logic [31:0] rd;
        int lat;

        rst_n = 1'b0; req = '0; we_in = 1'b0; addr_in = '0; wdata_in = '0; be_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready_clear", ready_w[0], 1'b0);
        chk("reset_ready_noclear", ready_w[1], 1'b1);
        chk("reset_ready_noclear8", ready_w[2], 1'b1);
        chk("reset_done", done_w, 3'b000);
        chk("reset_rdata", rdata_w[0], 32'h0);

        rst_n = 1'b1;
        n = 0;
        while (!ready_w[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_sweep_edges", n, 16);
        for (int a = 0; a < 16; a++) model[0][a] = 32'h0;
        for (int a = 0; a < 16; a++) op(0, 1'b0, 4'(a), 32'h0, 4'h0, "cleared_read");

        op(0, 1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, "wr_full");
        @(posedge clk); #1;
        chk("done_one_cycle", done_w[0], 1'b0);
        op(0, 1'b0, 4'd3, 32'h0, 4'h0, "rd_full");
        chk("rd_full_value", rdata_w[0], 32'hDEADBEEF);

        op(0, 1'b1, 4'd3, 32'h11223344, 4'b0101, "wr_partial");
        op(0, 1'b0, 4'd3, 32'h0, 4'h0, "rd_partial");
        chk("rd_partial_value", rdata_w[0], 32'hDE22BE44);
        op(0, 1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, "wr_nobytes");
        op(0, 1'b0, 4'd3, 32'h0, 4'h0, "rd_nobytes");
        chk("rd_nobytes_value", rdata_w[0], 32'hDE22BE44);

        for (int i = 0; i < 40; i++)
            op(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom), "random");

        op(0, 1'b1, 4'd3, 32'hA5A50003, 4'hF, "b2b_setup3");
        op(0, 1'b1, 4'd5, 32'h5A5A0005, 4'hF, "b2b_setup5");
        @(negedge clk);
        we_in = 1'b0; req[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr_in = i[0] ? 4'd3 : 4'd5;
            if (done_w[0] && rdq.size() > 0) chk("b2b_rdata", rdata_w[0], rdq.pop_front());
            if (ready_w[0]) begin
                acc.push_back(i);
                rdq.push_back(model[0][addr_in]);
            end
            @(negedge clk);
        end
        req[0] = 1'b0;
        g = 0;
        while (rdq.size() > 0 && g < 20) begin
            if (done_w[0]) begin
                last_rd = rdq.pop_front();
                chk("b2b_rdata_tail", rdata_w[0], last_rd);
            end
            @(negedge clk);
            g++;
        end
        chk("b2b_drained", rdq.size(), 0);
        chk("b2b_count", acc.size(), 6);
        for (int k = 1; k < acc.size(); k++) chk("b2b_spacing", acc[k] - acc[k-1], 3);
        held = rdata_w[0];
        chk("b2b_last_value", held, 32'hA5A50003);
        op(0, 1'b1, 4'd5, 32'h01020304, 4'hF, "hold_write");
        chk("rdata_hold_over_write", rdata_w[0], held);

        op(2, 1'b1, 4'd15, 32'h12345678, 4'hF, "lat8_wr");
        op(2, 1'b0, 4'd15, 32'h0, 4'h0, "lat8_rd");
        @(negedge clk);
        we_in = 1'b1; addr_in = 4'd15; wdata_in = 32'hCAFEF00D; be_in = 4'hF; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        chk("abort_accepted", ready_w[2], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_done", done_w[2], 1'b0);
        chk("abort_ready", ready_w[2], 1'b1);
        chk("abort_rdata", rdata_w[2], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) model[0][a] = 32'h0;
        op(2, 1'b0, 4'd15, 32'h0, 4'h0, "abort_not_committed");
        op(0, 1'b0, 4'd5, 32'h0, 4'h0, "resweep_cleared");

        op(1, 1'b1, 4'd7, $urandom, 4'hF, "lat1_wr7");
        op(1, 1'b1, 4'd8, 32'h0BADC0DE, 4'hF, "lat1_wr8");
        chk("lat1_ready_in_done", ready_w[1], 1'b1);
        we_in = 1'b0; addr_in = 4'd8; req[1] = 1'b1;
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("lat1_accept_in_done", ready_w[1], 1'b0);
        chk("lat1_done_low", done_w[1], 1'b0);
        @(posedge clk); #1;
        chk("lat1_done_next", done_w[1], 1'b1);
        chk("lat1_rdata", rdata_w[1], 32'h0BADC0DE);
        op(1, 1'b0, 4'd7, 32'h0, 4'h0, "lat1_rd7");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
